// File: rtl/reset_sequencer.sv
// reset_sequencer: orders mem/video reset release using PLL lock and SDRAM init status.
// Define RSTSEQ_TIMEOUT_EN to add the MEM_INIT timeout, FAULT backoff and retry counter.
module reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_WAIT    = 1000,
  parameter int VIDEO_DELAY  = 256,
  parameter int INIT_TIMEOUT = 65535
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  output logic       mem_reset,
  output logic       video_reset,
  output logic       sys_ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);
  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABLE    = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;
  localparam logic [2:0] VIDEO_DLY = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] FAULT     = 3'd5;
  localparam int MAX_A = LOCK_WAIT > VIDEO_DELAY ? LOCK_WAIT : VIDEO_DELAY;
  localparam int MAX_B = INIT_TIMEOUT > 16 ? INIT_TIMEOUT : 16;
  localparam int CW = $clog2((MAX_A > MAX_B ? MAX_A : MAX_B) + 1);
  localparam logic [CW-1:0] LW_END = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] VD_END = CW'(VIDEO_DELAY - 1);
  localparam logic [CW-1:0] FH_END = CW'(15);
`ifdef RSTSEQ_TIMEOUT_EN
  localparam logic [CW-1:0] IT_END = CW'(INIT_TIMEOUT - 1);
  logic to_hit;
`endif
  logic [SYNC_STAGES-1:0] lk_sr, id_sr;
  logic [2:0] st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic lk, id;
  assign lk = lk_sr[SYNC_STAGES-1];
  assign id = id_sr[SYNC_STAGES-1];
  always_comb begin
    st_nx = st;
    cnt_nx = cnt + 1'b1;
`ifdef RSTSEQ_TIMEOUT_EN
    to_hit = 1'b0;
`endif
    if (st != WAIT_LOCK && !lk) begin
      st_nx = WAIT_LOCK;
      cnt_nx = '0;
    end else begin
      case (st)
        WAIT_LOCK: begin
          cnt_nx = '0;
          st_nx = lk ? STABLE : WAIT_LOCK;
        end
        STABLE:
          if (cnt == LW_END) begin
            st_nx = MEM_INIT;
            cnt_nx = '0;
          end
        MEM_INIT:
          if (id) begin
            st_nx = VIDEO_DLY;
            cnt_nx = '0;
          end
`ifdef RSTSEQ_TIMEOUT_EN
          else if (cnt == IT_END) begin
            st_nx = FAULT;
            cnt_nx = '0;
            to_hit = 1'b1;
          end
`endif
        VIDEO_DLY:
          if (cnt == VD_END) st_nx = RUN;
        RUN:
          cnt_nx = cnt;
        FAULT:
          if (cnt == FH_END) begin
            st_nx = STABLE;
            cnt_nx = '0;
          end
        default: begin
          st_nx = WAIT_LOCK;
          cnt_nx = '0;
        end
      endcase
    end
  end
  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      lk_sr <= '0;
      id_sr <= '0;
      st <= WAIT_LOCK;
      cnt <= '0;
      mem_reset <= 1'b1;
      video_reset <= 1'b1;
      sys_ready <= 1'b0;
    end else begin
      lk_sr <= {lk_sr[SYNC_STAGES-2:0], pll_locked};
      id_sr <= {id_sr[SYNC_STAGES-2:0], sdram_init_done};
      st <= st_nx;
      cnt <= cnt_nx;
      mem_reset <= st_nx == WAIT_LOCK || st_nx == STABLE || st_nx == FAULT;
      video_reset <= st_nx != RUN;
      sys_ready <= st_nx == RUN;
    end
  end
`ifdef RSTSEQ_TIMEOUT_EN
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      fault <= 1'b0;
      retry_cnt <= '0;
    end else if (to_hit) begin
      fault <= 1'b1;
      retry_cnt <= retry_cnt == 4'd15 ? retry_cnt : retry_cnt + 4'd1;
    end
  end
`else
  assign fault = 1'b0;
  assign retry_cnt = '0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: vector table, directed corner sequences and a randomized run against a milestone model.
module tb_reset_sequencer;
  localparam int SS = 2, LW = 8, VD = 4, IT = 32;
  logic clk_100Mhz = 1'b0;
  logic reset = 1'b1, pll_locked = 1'b0, sdram_init_done = 1'b0;
  logic mem_reset, video_reset, sys_ready, fault;
  logic [3:0] retry_cnt;
  int n_pass = 0, n_total = 0;

  reset_sequencer #(.SYNC_STAGES(SS), .LOCK_WAIT(LW), .VIDEO_DELAY(VD), .INIT_TIMEOUT(IT)) dut (
    .clk_100Mhz(clk_100Mhz), .reset(reset), .pll_locked(pll_locked),
    .sdram_init_done(sdram_init_done), .mem_reset(mem_reset), .video_reset(video_reset),
    .sys_ready(sys_ready), .fault(fault), .retry_cnt(retry_cnt)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  // Model: delay lines for the synchronizers plus countdowns toward each release milestone.
  bit q_lk[$], q_id[$];
  bit awaiting = 1'b1, in_init = 1'b0, running = 1'b0, m_fault = 1'b0;
  int stable_left = 0, init_age = 0, video_left = 0, hold_left = 0, m_retry = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_edge();
    bit lk, id;
    if (reset) begin
      q_lk.delete();
      q_id.delete();
      for (int i = 0; i < SS; i++) begin
        q_lk.push_back(1'b0);
        q_id.push_back(1'b0);
      end
      awaiting = 1'b1; in_init = 1'b0; running = 1'b0; m_fault = 1'b0;
      stable_left = 0; init_age = 0; video_left = 0; hold_left = 0; m_retry = 0;
    end else begin
      lk = q_lk.pop_front();
      id = q_id.pop_front();
      q_lk.push_back(pll_locked);
      q_id.push_back(sdram_init_done);
      if (!lk) begin
        awaiting = 1'b1; in_init = 1'b0; running = 1'b0;
        stable_left = 0; video_left = 0; hold_left = 0;
      end else if (awaiting) begin
        awaiting = 1'b0;
        stable_left = LW;
      end else if (stable_left > 0) begin
        stable_left--;
        if (stable_left == 0) begin
          in_init = 1'b1;
          init_age = 0;
        end
      end else if (in_init) begin
        init_age++;
        if (id) begin
          in_init = 1'b0;
          video_left = VD;
        end
`ifdef RSTSEQ_TIMEOUT_EN
        else if (init_age == IT) begin
          in_init = 1'b0;
          hold_left = 16;
          m_fault = 1'b1;
          m_retry = m_retry < 15 ? m_retry + 1 : 15;
        end
`endif
      end else if (video_left > 0) begin
        video_left--;
        if (video_left == 0) running = 1'b1;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) stable_left = LW;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_100Mhz);
    model_edge();
    #2;
  endtask

  typedef struct {
    bit rst, pll, init;
    int edges;
    bit mem, vid, rdy;
  } vec_t;
  vec_t tbl [0:9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 10; v++) begin
      reset = tbl[v].rst;
      pll_locked = tbl[v].pll;
      sdram_init_done = tbl[v].init;
      repeat (tbl[v].edges) tick();
      check($sformatf("vec%0d mem_reset", v), mem_reset, tbl[v].mem);
      check($sformatf("vec%0d video_reset", v), video_reset, tbl[v].vid);
      check($sformatf("vec%0d sys_ready", v), sys_ready, tbl[v].rdy);
      check($sformatf("vec%0d fault", v), fault, 0);
      check($sformatf("vec%0d retry_cnt", v), retry_cnt, 0);
    end

    // Lock glitch while STABLE at cnt=5 restarts the full stability wait.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sdram_init_done = 1'b0;
    for (int e = 0; e <= 20; e++) begin
      pll_locked = e != 6;
      tick();
      check($sformatf("glitch e%0d mem_reset", e), mem_reset, e >= 17 ? 0 : 1);
    end

`ifdef RSTSEQ_TIMEOUT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pll_locked = 1'b1;
    sdram_init_done = 1'b0;
    for (int e = 0; e < 1000; e++) begin
      tick();
      if (e == 41) check("pre-timeout fault", fault, 0);
      if (e == 42) check("timeout fault", fault, 1);
      if (e == 42 || e == 97) check($sformatf("retry e%0d", e), retry_cnt, 1);
      if (e == 98) check("second retry", retry_cnt, 2);
      if (e >= 41 && e <= 67) check($sformatf("backoff e%0d mem_reset", e), mem_reset, (e >= 42 && e <= 65) ? 1 : 0);
      if (e == 999) check("retry saturate", retry_cnt, 15);
    end
`else
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pll_locked = 1'b1;
    sdram_init_done = 1'b0;
    repeat (200) tick();
    check("no-timeout mem_reset", mem_reset, 0);
    check("no-timeout video_reset", video_reset, 1);
    check("no-timeout fault", fault, 0);
    check("no-timeout retry", retry_cnt, 0);
`endif

    // Reset asserted in VIDEO_DLY.
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    repeat (4) tick();
    check("flush mem_reset", mem_reset, 1);
`ifdef RSTSEQ_TIMEOUT_EN
    check("sticky fault after lock loss", fault, 1);
`endif
    pll_locked = 1'b1;
    sdram_init_done = 1'b1;
    repeat (12) tick();
    check("vdly mem_reset", mem_reset, 0);
    check("vdly video_reset", video_reset, 1);
    check("vdly sys_ready", sys_ready, 0);
    reset = 1'b1;
    tick();
    check("rst mem_reset", mem_reset, 1);
    check("rst video_reset", video_reset, 1);
    check("rst sys_ready", sys_ready, 0);
    check("rst fault", fault, 0);
    check("rst retry_cnt", retry_cnt, 0);
    reset = 1'b0;

    // Randomized run compared against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 499) == 0;
      pll_locked = $urandom_range(0, 99) >= 3;
      if ($urandom_range(0, 39) == 0) sdram_init_done = ~sdram_init_done;
      tick();
      check($sformatf("rnd%0d mem_reset", c), mem_reset, (awaiting || stable_left > 0 || hold_left > 0) ? 1 : 0);
      check($sformatf("rnd%0d video_reset", c), video_reset, running ? 0 : 1);
      check($sformatf("rnd%0d sys_ready", c), sys_ready, running ? 1 : 0);
      check($sformatf("rnd%0d fault", c), fault, m_fault ? 1 : 0);
      check($sformatf("rnd%0d retry_cnt", c), retry_cnt, m_retry);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
